// File: rtl/led_arbiter_if.sv
// LED bank sharing bus: per-client request/pattern in, owner grant and LED drive out.
// Latency: none; this is plain wiring between the clients and the arbiter.
// Backpressure: none; a client holds req high until it appears in grant.
interface led_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [6*NREQ-1:0] pattern;
    logic [NREQ-1:0]   grant;
    logic [5:0]        leds;
    logic              blink;
    logic              tick;

    // Requester side: drives requests and patterns, observes the bank.
    modport master (
        output req,
        output pattern,
        input  grant,
        input  leds,
        input  blink,
        input  tick
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  pattern,
        output grant,
        output leds,
        output blink,
        output tick
    );
endinterface

// File: rtl/led_arbiter.sv
// Round-robin owner of the 6-LED bank and blink LED, with an idle heartbeat on blink.
// Latency: grant 1 cycle after req is sampled; leds show the owner pattern 1 cycle later.
// Backpressure: none; clients hold req, and an owner keeps the bank for >= SLOT_TICKS ticks.
module led_arbiter #(
    parameter int         NREQ         = 4,
    parameter int         PRESCALE_W   = 23,
    parameter int         SLOT_TICKS   = 4,
    parameter logic [5:0] IDLE_PATTERN = 6'b000000
) (
    input logic          clk50,
    input logic          rst_n,
    led_arbiter_if.slave bus
);
    // Client index width; NREQ is 2..8 so this is 1..3 bits.
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // SLOT_TICKS is at most 15, so a 4-bit saturating counter covers it.
    localparam int SCW = 4;
    localparam logic [SCW-1:0]  SLOT_MAX = SCW'(SLOT_TICKS);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Registered state and outputs.
    logic [PRESCALE_W-1:0] pres_q;
    logic [PRESCALE_W-1:0] pres_d;
    logic                  tick_q;
    state_t                state_q;
    logic [NREQ-1:0]       grant_q;
    logic [5:0]            leds_q;
    logic                  blink_q;
    logic [SCW-1:0]        slot_q;
    // Last client granted; while in OWN this is also the current owner.
    logic [IDXW-1:0]       last_q;

    // Arbitration helpers.
    logic                  rr_found;
    logic [IDXW-1:0]       rr_winner;
    logic [IDXW:0]         rr_sum;
    logic [NREQ-1:0]       rr_grant;
    logic [5:0]            own_pat;
    logic                  owner_req;
    logic                  others_req;
    logic                  slot_sat;

    assign bus.grant = grant_q;
    assign bus.leds  = leds_q;
    assign bus.blink = blink_q;
    assign bus.tick  = tick_q;

    // Next prescaler value; the counter simply wraps.
    always_comb begin
        pres_d = pres_q + 1'b1;
    end

    // Free-running prescaler; tick is registered so it is high exactly while the count is all-ones.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            pres_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pres_q <= pres_d;
            tick_q <= &pres_d;
        end
    end

    // Round-robin search: first asserted req starting at last_q+1, wrapping modulo NREQ.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_q;
        rr_sum    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_sum = {1'b0, last_q} + (IDXW+1)'(k);
            if (rr_sum >= (IDXW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IDXW+1)'(NREQ);
            end
            if (!rr_found && bus.req[rr_sum[IDXW-1:0]]) begin
                rr_found  = 1'b1;
                rr_winner = rr_sum[IDXW-1:0];
            end
        end
        rr_grant = ONE << rr_winner;
    end

    // Owner pattern mux plus release/preempt conditions, all keyed off the registered grant.
    always_comb begin
        own_pat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (last_q == IDXW'(i)) begin
                own_pat = bus.pattern[6*i +: 6];
            end
        end
        owner_req  = |(bus.req & grant_q);
        others_req = |(bus.req & ~grant_q);
        slot_sat   = (slot_q == SLOT_MAX);
    end

    // Ownership FSM with registered grant/leds/blink and the slot counter.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            leds_q  <= IDLE_PATTERN;
            blink_q <= 1'b0;
            slot_q  <= '0;
            last_q  <= IDXW'(NREQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    grant_q <= '0;
                    leds_q  <= IDLE_PATTERN;
                    if (tick_q) begin
                        blink_q <= ~blink_q;
                    end
                    if (rr_found) begin
                        // leds keep the idle pattern for this one cycle; the
                        // owner pattern is loaded from the next edge on.
                        state_q <= S_OWN;
                        grant_q <= rr_grant;
                        last_q  <= rr_winner;
                        slot_q  <= '0;
                        blink_q <= 1'b1;
                    end
                end

                S_OWN: begin
                    leds_q  <= own_pat;
                    blink_q <= 1'b1;
                    if (tick_q && !slot_sat) begin
                        slot_q <= slot_q + 1'b1;
                    end
                    // Release and preempt lead to the same GAP, so they share one branch.
                    if (!owner_req || (slot_sat && others_req)) begin
                        state_q <= S_GAP;
                        grant_q <= '0;
                        leds_q  <= '0;
                        blink_q <= 1'b0;
                        slot_q  <= '0;
                    end
                end

                S_GAP: begin
                    // Single dark cycle between owners; ticks here only advance the prescaler.
                    slot_q <= '0;
                    if (rr_found) begin
                        state_q <= S_OWN;
                        grant_q <= rr_grant;
                        last_q  <= rr_winner;
                        blink_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        leds_q  <= IDLE_PATTERN;
                        blink_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    leds_q  <= IDLE_PATTERN;
                    blink_q <= 1'b0;
                    slot_q  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with PRESCALE_W=3 (tick every 8 cycles) and SLOT_TICKS=2.
// Edge n counts rising edges since reset release; after edge n the prescaler holds n%8.
// Inputs are changed and outputs sampled 1 time unit after a rising edge.
module tb_led_arbiter;
    localparam int         NREQ   = 4;
    localparam int         PW     = 3;
    localparam int         ST     = 2;
    localparam logic [5:0] IDLE_P = 6'h15;

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n = 0;

    // Round-robin expectations with req=1111: edge number and grant after it.
    int         rr_e [11] = '{1, 16, 17, 18, 32, 33, 34, 49, 50, 65, 66};
    logic [3:0] rr_g [11] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                              4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    led_arbiter_if #(.NREQ(NREQ)) bus();

    led_arbiter #(
        .NREQ(NREQ),
        .PRESCALE_W(PW),
        .SLOT_TICKS(ST),
        .IDLE_PATTERN(IDLE_P)
    ) dut (
        .clk50(clk50),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk50 = ~clk50;

    task automatic step(input int cnt);
        repeat (cnt) begin
            @(posedge clk50);
            #1;
            n++;
        end
    endtask

    task automatic step_to(input int target);
        step(target - n);
    endtask

    task automatic set_pat(input int idx, input logic [5:0] v);
        bus.pattern[6*idx +: 6] = v;
    endtask

    task automatic reset_dut();
        @(posedge clk50);
        #2;
        rst_n   = 1'b0;
        bus.req = '0;
        #12;
        @(negedge clk50);
        rst_n = 1'b1;
        n     = 0;
    endtask

    task automatic test_reset();
        @(posedge clk50);
        #2;
        rst_n   = 1'b0;
        bus.req = '0;
        #3;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
        checks++; if (bus.leds !== IDLE_P) begin errors++; $display("FAIL rst_leds: got %h want %h", bus.leds, IDLE_P); end
        checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL rst_blink: got %b want 0", bus.blink); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", bus.tick); end
        @(negedge clk50);
        rst_n = 1'b1;
        n     = 0;
        step_to(6);
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL tick_e6: got %b want 0", bus.tick); end
        step_to(7);
        checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL tick_e7: got %b want 1", bus.tick); end
        checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL blink_e7: got %b want 0", bus.blink); end
        step_to(8);
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL tick_e8: got %b want 0", bus.tick); end
        checks++; if (bus.blink !== 1'b1) begin errors++; $display("FAIL blink_e8: got %b want 1", bus.blink); end
        step_to(15);
        checks++; if (bus.blink !== 1'b1) begin errors++; $display("FAIL blink_e15: got %b want 1", bus.blink); end
        step_to(16);
        checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL blink_e16: got %b want 0", bus.blink); end
        step_to(24);
        checks++; if (bus.blink !== 1'b1) begin errors++; $display("FAIL blink_e24: got %b want 1", bus.blink); end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL idle_grant: got %b want 0000", bus.grant); end
        checks++; if (bus.leds !== IDLE_P) begin errors++; $display("FAIL idle_leds: got %h want %h", bus.leds, IDLE_P); end
    endtask

    task automatic test_reset_mid_own();
        reset_dut();
        set_pat(0, 6'h3C);
        bus.req = 4'b0001;
        step_to(7);
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL mid_pre_grant: got %b want 0001", bus.grant); end
        checks++; if (bus.leds !== 6'h3C) begin errors++; $display("FAIL mid_pre_leds: got %h want 3c", bus.leds); end
        checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL mid_pre_tick: got %b want 1", bus.tick); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL mid_rst_grant: got %b want 0000", bus.grant); end
        checks++; if (bus.leds !== IDLE_P) begin errors++; $display("FAIL mid_rst_leds: got %h want %h", bus.leds, IDLE_P); end
        checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL mid_rst_blink: got %b want 0", bus.blink); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick: got %b want 0", bus.tick); end
        bus.req = '0;
    endtask

    task automatic test_single();
        reset_dut();
        set_pat(2, 6'h2A);
        bus.req = 4'b0100;
        step_to(1);
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", bus.grant); end
        checks++; if (bus.blink !== 1'b1) begin errors++; $display("FAIL single_blink: got %b want 1", bus.blink); end
        step_to(2);
        checks++; if (bus.leds !== 6'h2A) begin errors++; $display("FAIL single_leds: got %h want 2a", bus.leds); end
        set_pat(2, 6'h11);
        #1;
        checks++; if (bus.leds !== 6'h2A) begin errors++; $display("FAIL track_hold: got %h want 2a", bus.leds); end
        step_to(3);
        checks++; if (bus.leds !== 6'h11) begin errors++; $display("FAIL track_new: got %h want 11", bus.leds); end
        bus.req = 4'b0000;
        step_to(4);
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rel_grant: got %b want 0000", bus.grant); end
        checks++; if (bus.leds !== 6'h00) begin errors++; $display("FAIL rel_gap_leds: got %h want 00", bus.leds); end
        checks++; if (bus.blink !== 1'b0) begin errors++; $display("FAIL rel_gap_blink: got %b want 0", bus.blink); end
        step_to(5);
        checks++; if (bus.leds !== IDLE_P) begin errors++; $display("FAIL rel_idle_leds: got %h want %h", bus.leds, IDLE_P); end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rel_idle_grant: got %b want 0000", bus.grant); end
    endtask

    task automatic test_round_robin();
        int p;
        int multi;
        p     = 0;
        multi = 0;
        reset_dut();
        set_pat(0, 6'h01);
        set_pat(1, 6'h02);
        set_pat(2, 6'h04);
        set_pat(3, 6'h08);
        bus.req = 4'b1111;
        while (n < 66) begin
            step(1);
            if ($countones(bus.grant) > 1) multi++;
            if (p < 11 && n == rr_e[p]) begin
                checks++;
                if (bus.grant !== rr_g[p]) begin
                    errors++;
                    $display("FAIL rr_edge%0d: got %b want %b", n, bus.grant, rr_g[p]);
                end
                p++;
            end
            if (n == 19) begin
                checks++; if (bus.leds !== 6'h02) begin errors++; $display("FAIL rr_leds_e19: got %h want 02", bus.leds); end
            end
        end
        checks++; if (multi !== 0) begin errors++; $display("FAIL rr_onehot: got %0d multi-hot cycles want 0", multi); end
        bus.req = '0;
    endtask

    task automatic test_no_early_preempt();
        reset_dut();
        bus.req = 4'b0010;
        step_to(1);
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL ne_grant1: got %b want 0010", bus.grant); end
        step_to(9);
        bus.req = 4'b1010;
        step_to(12);
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL ne_e12: got %b want 0010", bus.grant); end
        step_to(16);
        checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL ne_e16: got %b want 0010", bus.grant); end
        step_to(17);
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL ne_gap: got %b want 0000", bus.grant); end
        step_to(18);
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL ne_grant3: got %b want 1000", bus.grant); end
        bus.req = '0;
    endtask

    task automatic test_sole_owner();
        int bad;
        bad = 0;
        reset_dut();
        set_pat(0, 6'h27);
        bus.req = 4'b0001;
        step_to(1);
        repeat (160) begin
            step(1);
            if (bus.grant !== 4'b0001 || bus.blink !== 1'b1 || bus.leds !== 6'h27) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL sole_hold: got %0d bad cycles want 0", bad); end
        bus.req = '0;
    endtask

    task automatic test_simul_release_preempt();
        reset_dut();
        set_pat(2, 6'h33);
        bus.req = 4'b0001;
        step_to(16);
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL sim_own: got %b want 0001", bus.grant); end
        bus.req = 4'b0100;
        step_to(17);
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL sim_gap_grant: got %b want 0000", bus.grant); end
        checks++; if (bus.leds !== 6'h00) begin errors++; $display("FAIL sim_gap_leds: got %h want 00", bus.leds); end
        step_to(18);
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL sim_grant2: got %b want 0100", bus.grant); end
        step_to(19);
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL sim_hold2: got %b want 0100", bus.grant); end
        checks++; if (bus.leds !== 6'h33) begin errors++; $display("FAIL sim_leds2: got %h want 33", bus.leds); end
        bus.req = '0;
    endtask

    initial begin
        bus.req     = '0;
        bus.pattern = '0;
        test_reset();
        test_reset_mid_own();
        test_single();
        test_round_robin();
        test_no_early_preempt();
        test_sole_owner();
        test_simul_release_preempt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_arbiter.md
# led_arbiter

Shares the board's 6-LED bank and blink LED among NREQ independent requesters, e.g. the status, debug and heartbeat sources in the top-level design. It runs a free-running prescaler tick, gives the bank to one requester at a time in round-robin order, and guarantees each owner a minimum hold of SLOT_TICKS ticks before another requester can preempt it. When no requester is active, it drives an idle pattern and a heartbeat on blink.

## Interface
- NREQ, 4: number of requesters, 2..8.
- PRESCALE_W, 23: prescaler width; one tick every 2^PRESCALE_W cycles (about 168 ms at 50 MHz).
- SLOT_TICKS, 4: ticks an owner is guaranteed before preemption, 1..15.
- IDLE_PATTERN, 6'b000000: value on leds in IDLE.
- clk50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  request per client, level-sensitive.
- pattern  in  6*NREQ  LED pattern per client; client i uses bits [6i+5:6i].
- grant  out  NREQ  one-hot owner, registered.
- leds  out  6  LED bank drive, registered.
- blink  out  1  blink LED drive, registered.
- tick  out  1  one-cycle prescaler pulse.

## Operation
- Prescaler:
  - PRESCALE_W-bit up-counter that wraps.
  - tick=1 in the cycle the counter equals all-ones.
  - Runs in every state.
- States are IDLE, OWN and GAP. Reset state is IDLE.
- IDLE:
  - grant=0, leds=IDLE_PATTERN.
  - blink toggles on each tick.
  - If any req bit is 1, pick the winner by round-robin and go to OWN.
- Round-robin:
  - Search starts at last+1 (mod NREQ) and takes the first asserted req.
  - last updates to the winner on each grant.
  - last resets to NREQ-1, so client 0 has first priority after reset.
- OWN:
  - grant is one-hot to the owner; blink=1.
  - leds load pattern[owner] every cycle, so pattern changes are tracked with 1-cycle lag.
  - slot_cnt clears on entry, increments on tick, and saturates at SLOT_TICKS.
- Exit from OWN to GAP, when either holds:
  - req[owner]=0 (release); or
  - slot_cnt==SLOT_TICKS and any other req bit is 1 (preempt).
  - If both hold in the same cycle, it is handled as a release; the result is identical.
- Staying in OWN: if slot_cnt is saturated and no other client is requesting, the owner keeps the bank indefinitely.
- GAP:
  - Lasts exactly 1 cycle; grant=0, leds=0, blink=0.
  - Next state is OWN (new arbitration, same round-robin rule) if any req bit is 1, else IDLE.
  - A released owner that re-requests competes normally; it wins only if no other client is requesting.
- Ticks during GAP are counted by the prescaler only; they have no slot or blink effect.

## Timing
- Reset values: grant=0, leds=IDLE_PATTERN, blink=0, tick=0, prescaler=0, slot_cnt=0, last=NREQ-1, state=IDLE.
- rst_n assertion forces all registers immediately, including in the middle of an OWN session.
- Release of rst_n: the first tick is at cycle 2^PRESCALE_W-1 after the first active edge.
- Grant latency:
  - req sampled at edge E in IDLE/GAP → grant and state=OWN valid after E.
  - leds = pattern valid after E+1.
- Release latency:
  - req[owner] low sampled at edge E → grant=0 and leds=0 after E (GAP).
  - Next grant is visible after E+1.
- Preempt: fires on the edge where slot_cnt==SLOT_TICKS and another req is sampled high; minimum ownership is SLOT_TICKS ticks.
- Gap: there is always ≥1 cycle with grant=0 between two owners; grant is never multi-hot.
- All outputs are registered; there is no combinational path from req/pattern to outputs.

## Test plan
- Reset:
  - Assert rst_n=0 mid-OWN → outputs go to reset values within the same cycle.
  - After release, with no requests, blink toggles every 8 cycles (PRESCALE_W=3).
- Single request:
  - req=4'b0100, pattern[2]=6'h2A at edge E → grant=4'b0100 after E, leds=6'h2A after E+1.
  - Drop req → GAP then IDLE, leds=IDLE_PATTERN.
- Round-robin (PRESCALE_W=3, SLOT_TICKS=2):
  - req=4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001.
  - Each owner holds 2 ticks; each handover has a 1-cycle grant=0 gap.
- No early preemption:
  - Client 1 owns; client 3 requests after 1 tick → client 1 keeps the bank until slot_cnt=2, then client 3 is granted.
- Sole owner persists: client 0 alone holds for 20 ticks → grant stays 4'b0001 with no GAP.
- Simultaneous release and preempt:
  - Owner drops req on the same edge slot_cnt saturates while client 2 requests → single GAP cycle, then grant=4'b0100.
  - Verify pattern tracking: change the owner's pattern mid-OWN → leds follow 1 cycle later.
